// File: rtl/sreg_loader.sv
// sreg_loader: walks a ROM address range and streams each word downstream on valid/ready.
module sreg_loader #(
    parameter int addr_w = 4,
    parameter int data_w = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [addr_w-1:0] start_addr,
    input  logic [addr_w:0]   count,
    output logic [addr_w-1:0] r_addr,
    input  logic [data_w-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_data,
    output logic [addr_w-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
    localparam logic [addr_w:0] full = {1'b1, {addr_w{1'b0}}};
    state_t state, state_n;
    logic [addr_w:0] remaining, remaining_n, sat_count;
    logic [addr_w-1:0] addr_n, idx_n;
    logic last;
    assign sat_count = count > full ? full : count;
    assign last = remaining == (addr_w+1)'(1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            r_addr    <= '0;
            out_idx   <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            r_addr    <= addr_n;
            out_idx   <= idx_n;
        end
    end
    // r_addr only moves on an accepted word, so rom_data holds steady under backpressure
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        addr_n      = r_addr;
        idx_n       = out_idx;
        case (state)
            IDLE:
                if (start) begin
                    if (count != '0) begin
                        remaining_n = sat_count;
                        addr_n      = start_addr;
                        idx_n       = '0;
                        state_n     = FETCH;
                    end else begin
                        state_n = DONE;
                    end
                end
            FETCH: state_n = EMIT;
            EMIT:
                if (out_ready) begin
                    if (last) begin
                        state_n = DONE;
                    end else begin
                        addr_n      = r_addr + addr_w'(1);
                        idx_n       = out_idx + addr_w'(1);
                        remaining_n = remaining - (addr_w+1)'(1);
                        state_n     = FETCH;
                    end
                end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign out_valid = state == EMIT;
    assign out_data  = rom_data;
    assign out_last  = out_valid && last;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
endmodule
